alu_rv_pipe: RTL and testbench
==============================

// Module: alu_rv_pipe
// PURPOSE
//  Parametrised, pipelined RV32I/RV64I integer execute unit for OP and OP-IMM instructions.
//  Decodes the raw instruction and sign-extends the immediate, then computes the result.
//  Uses valid/ready handshakes on both sides, so the hazard/issue logic can stall it.
//  Sits between register-file read and writeback.
// PARAMETERS
//  XLEN      32  datapath width; legal values 32 or 64
//  SHW       $clog2(XLEN)  shift-amount width (derived, localparam)
// PORTS
//  clock          in   1     system clock, rising edge
//  reset          in   1     asynchronous, active-high reset
//  in_valid       in   1     instruction + operands presented
//  in_ready       out  1     unit accepts the transaction this cycle
//  instruction    in   32    raw instruction word
//  rs1_value      in   XLEN  rs1 operand (already read)
//  rs2_value      in   XLEN  rs2 operand (already read)
//  rs1            out  5     instruction[19:15], combinational, for register-file addressing
//  rs2            out  5     instruction[24:20], combinational
//  out_valid      out  1     result held on rd/rd_result/rd_write/illegal
//  out_ready      in   1     downstream accepts the result
//  rd             out  5     destination register
//  rd_result      out  XLEN  ALU result
//  rd_write       out  1     1 = write back (legal op and rd != 0)
//  illegal        out  1     unsupported opcode/funct encoding
//  pc, branch_taken, branch_target: present only with ALU_RV_BRANCH_EN (see CONFIGURATION)
// BEHAVIOUR
//  - Two register stages. S0 holds decoded fields, operand A, operand B and opsel.
//    S1 holds the result.
//  - Handshake: a transfer occurs on an edge where valid&&ready.
//    s1_adv = !out_valid || out_ready.
//    in_ready = !s0_valid || s1_adv (combinational, no dependence on in_valid).
//  - Latency: a transaction accepted at edge E appears at the outputs after edge E+1.
//    Throughput is 1/cycle. A stall holds both stages; outputs stay stable while out_valid && !out_ready.
//  - Reset: every stage valid, out_valid, rd, rd_result, rd_write and illegal go to 0.
//    In-flight transactions are dropped, with no partial output.
//  - Decode, opcode[6:0]:
//    - OP (0110011): operand B = rs2_value.
//    - OP-IMM (0010011): operand B = sext(instruction[31:20]) to XLEN.
//    - Any other opcode: illegal=1, rd_result=0, rd_write=0.
//  - funct3 operations:
//    - 0: ADD/SUB. SUB only for OP with funct7=0x20. ADDI never subtracts.
//    - 1: SLL.
//    - 2: SLT (signed).
//    - 3: SLTU (unsigned; SLTIU compares against the sign-extended immediate as unsigned).
//    - 4: XOR. 5: SRL/SRA. 6: OR. 7: AND.
//  - Shifts: shamt = low SHW bits of operand B.
//    - For XLEN=32, an OP-IMM shift with instruction[25]=1 is illegal.
//    - For XLEN=64, instruction[25] is shamt[5].
//  - funct7 legality:
//    - OP: 0x00 for all funct3; 0x20 only for funct3 0 and 5; anything else is illegal.
//    - OP-IMM shifts: upper funct7 bits must be 0x00, or 0x20 for SRAI.
//  - Arithmetic wraps modulo 2^XLEN. SLT/SLTU produce 0 or 1 zero-extended.
//  - rd=x0: result is computed but rd_write=0.
//  - Simultaneous accept and drain in one cycle is legal and must not bubble.
// CONFIGURATION
//  ALU_RV_BRANCH_EN defined:
//  - Adds ports pc (in, XLEN), branch_taken (out, 1) and branch_target (out, XLEN).
//  - pc is registered with S0 and outputs are aligned with out_valid.
//  - BRANCH (1100011) is decoded as legal with rd_write=0 and rd_result=0.
//  - funct3 0/1/4/5/6/7 = BEQ/BNE/BLT/BGE/BLTU/BGEU; funct3 2/3 is illegal.
//  - branch_target = pc + sext({imm[12:1],1'b0}), computed whether the branch is taken or not.
//  - For non-branches, branch_taken=0 and branch_target=0. Reset value is 0.
//  ALU_RV_BRANCH_EN undefined: the ports do not exist and BRANCH is illegal.
// STRUCTURE
//  Shared package alu_rv_pkg:
//  - opcode constants OPC_OP, OPC_OP_IMM, OPC_BRANCH.
//  - funct3 constants F3_ADD..F3_AND and F3_BEQ..F3_BGEU.
//  - funct7 constants F7_BASE=7'h00 and F7_ALT=7'h20.
//  - typedef alu_op_e (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND).
//  One sub-module, alu_rv_core: purely combinational (alu_op_e, a, b) -> result, XLEN-parametrised.
//  It is instantiated in S1. Decode and handshake stay in alu_rv_pipe.
// TESTING
//  1 ADDI x5,x1,-1, rs1=0x10, out_ready=1 -> 2 cycles later out_valid, rd=5, rd_result=0x0F, rd_write=1.
//  2 SUB x3,x1,x2, rs1=0, rs2=1 -> rd_result=0xFFFFFFFF. SRA with rs1=0x80000000, rs2=4 -> 0xF8000000.
//  3 SLTIU imm=-1, rs1=5 -> 1. SLT rs1=0xFFFFFFFF, rs2=0 -> 1. SLTU with the same operands -> 0.
//  4 Back-to-back stream of 4 ops, out_ready low for 3 cycles mid-stream:
//    - in_ready drops once S0 and S1 are both full.
//    - outputs stay stable while stalled.
//    - all 4 results arrive in order, with no loss and no duplication.
//  5 Opcode 0110111, or OP with funct7=0x01 -> illegal=1, rd_write=0. ADD with rd=0 -> rd_write=0.
//  6 Assert reset while 2 ops are in flight -> out_valid=0 immediately.
//    After deassert, the next accepted op is the first output.
//    With ALU_RV_BRANCH_EN: BEQ, pc=0x100, imm=-8, equal operands -> branch_taken=1, branch_target=0xF8.

Source files
------------

// File: rtl/alu_rv_pkg.sv
// Shared opcode/funct constants, ALU operation encoding and funct3 decode
// helper for the RV32I/RV64I execute unit.
package alu_rv_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SRL  = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;

    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND
    } alu_op_e;

    // alt selects SUB for funct3 0 and SRA for funct3 5; ignored otherwise.
    function automatic alu_op_e f3_to_op(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SRL:  op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_rv_core.sv
// Combinational integer ALU: (op, a, b) -> result, XLEN wide.
module alu_rv_core
    import alu_rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  alu_op_e         op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result
);

    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0] shamt;

    assign shamt = b[SHW-1:0];

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLL:  result = a << shamt;
            ALU_SLT:  result = XLEN'($signed(a) < $signed(b));
            ALU_SLTU: result = XLEN'(a < b);
            ALU_XOR:  result = a ^ b;
            ALU_SRL:  result = a >> shamt;
            ALU_SRA:  result = XLEN'($signed(a) >>> shamt);
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/alu_rv_pipe.sv
// Two-stage RV32I/RV64I OP/OP-IMM execute unit with valid/ready on both sides.
// Define ALU_RV_BRANCH_EN to add conditional-branch resolution (pc/branch_* ports).
module alu_rv_pipe
    import alu_rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instruction,
    input  logic [XLEN-1:0] rs1_value,
    input  logic [XLEN-1:0] rs2_value,
`ifdef ALU_RV_BRANCH_EN
    input  logic [XLEN-1:0] pc,
    output logic            branch_taken,
    output logic [XLEN-1:0] branch_target,
`endif
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] rd_result,
    output logic            rd_write,
    output logic            illegal
);

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [6:0]      shf7;
    logic [XLEN-1:0] imm_i;

    alu_op_e         dec_op;
    logic [XLEN-1:0] dec_b;
    logic            dec_illegal;
    logic            dec_branch;

    logic            s0_valid;
    logic [4:0]      s0_rd;
    alu_op_e         s0_op;
    logic [XLEN-1:0] s0_a;
    logic [XLEN-1:0] s0_b;
    logic            s0_illegal;
    logic            s0_write;
    logic            s0_branch;

    logic            s1_adv;
    logic [XLEN-1:0] alu_result;

    assign opcode = instruction[6:0];
    assign f3     = instruction[14:12];
    assign f7     = instruction[31:25];
    assign rs1    = instruction[19:15];
    assign rs2    = instruction[24:20];
    assign imm_i  = {{(XLEN-12){instruction[31]}}, instruction[31:20]};

    // On RV64 instruction[25] is shamt[5], so it is excluded from the funct7 check.
    assign shf7 = (XLEN == 64) ? {instruction[31:26], 1'b0} : instruction[31:25];

    always_comb begin
        dec_op      = f3_to_op(f3, 1'b0);
        dec_b       = rs2_value;
        dec_illegal = 1'b1;
        dec_branch  = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec_illegal = !((f7 == F7_BASE) ||
                                ((f7 == F7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SRL))));
                dec_op      = f3_to_op(f3, f7 == F7_ALT);
            end
            OPC_OP_IMM: begin
                dec_b       = imm_i;
                dec_illegal = 1'b0;
                if (f3 == F3_SLL)
                    dec_illegal = (shf7 != F7_BASE);
                if (f3 == F3_SRL)
                    dec_illegal = (shf7 != F7_BASE) && (shf7 != F7_ALT);
                dec_op      = f3_to_op(f3, (f3 == F3_SRL) && (shf7 == F7_ALT));
            end
`ifdef ALU_RV_BRANCH_EN
            OPC_BRANCH: begin
                dec_branch  = 1'b1;
                dec_illegal = (f3 == 3'd2) || (f3 == 3'd3);
            end
`endif
            default: ;
        endcase
    end

    assign s1_adv   = !out_valid || out_ready;
    assign in_ready = !s0_valid || s1_adv;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s0_valid   <= 1'b0;
            s0_rd      <= '0;
            s0_op      <= ALU_ADD;
            s0_a       <= '0;
            s0_b       <= '0;
            s0_illegal <= 1'b0;
            s0_write   <= 1'b0;
            s0_branch  <= 1'b0;
        end else if (in_ready) begin
            s0_valid <= in_valid;
            if (in_valid) begin
                s0_rd      <= instruction[11:7];
                s0_op      <= dec_op;
                s0_a       <= rs1_value;
                s0_b       <= dec_b;
                s0_illegal <= dec_illegal;
                s0_write   <= !dec_illegal && !dec_branch && (instruction[11:7] != 5'd0);
                s0_branch  <= dec_branch;
            end
        end
    end

    alu_rv_core #(.XLEN(XLEN)) u_core (
        .op     (s0_op),
        .a      (s0_a),
        .b      (s0_b),
        .result (alu_result)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            rd        <= '0;
            rd_result <= '0;
            rd_write  <= 1'b0;
            illegal   <= 1'b0;
        end else if (s1_adv) begin
            out_valid <= s0_valid;
            if (s0_valid) begin
                rd        <= s0_rd;
                rd_result <= (s0_illegal || s0_branch) ? '0 : alu_result;
                rd_write  <= s0_write;
                illegal   <= s0_illegal;
            end
        end
    end

`ifdef ALU_RV_BRANCH_EN
    logic [2:0]      s0_f3;
    logic [XLEN-1:0] s0_pc;
    logic [XLEN-1:0] s0_imm_b;
    logic [XLEN-1:0] imm_b;
    logic            br_cond;

    assign imm_b = {{(XLEN-13){instruction[31]}}, instruction[31], instruction[7],
                    instruction[30:25], instruction[11:8], 1'b0};

    // Branch operands ride in s0_a / s0_b (rs1_value / rs2_value).
    always_comb begin
        br_cond = 1'b0;
        case (s0_f3)
            F3_BEQ:  br_cond = (s0_a == s0_b);
            F3_BNE:  br_cond = (s0_a != s0_b);
            F3_BLT:  br_cond = ($signed(s0_a) <  $signed(s0_b));
            F3_BGE:  br_cond = ($signed(s0_a) >= $signed(s0_b));
            F3_BLTU: br_cond = (s0_a <  s0_b);
            F3_BGEU: br_cond = (s0_a >= s0_b);
            default: br_cond = 1'b0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s0_f3         <= '0;
            s0_pc         <= '0;
            s0_imm_b      <= '0;
            branch_taken  <= 1'b0;
            branch_target <= '0;
        end else begin
            if (in_ready && in_valid) begin
                s0_f3    <= f3;
                s0_pc    <= pc;
                s0_imm_b <= imm_b;
            end
            if (s1_adv && s0_valid) begin
                branch_taken  <= s0_branch && !s0_illegal && br_cond;
                branch_target <= (s0_branch && !s0_illegal) ? (s0_pc + s0_imm_b) : '0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_rv_pipe.sv
// Directed-vector bench for alu_rv_pipe (XLEN=32); branch checks when ALU_RV_BRANCH_EN is defined.
module tb_alu_rv_pipe;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instruction;
    logic [31:0] rs1_value;
    logic [31:0] rs2_value;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  rd;
    logic [31:0] rd_result;
    logic        rd_write;
    logic        illegal;
`ifdef ALU_RV_BRANCH_EN
    logic [31:0] pc;
    logic        branch_taken;
    logic [31:0] branch_target;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    alu_rv_pipe #(.XLEN(32)) dut (
        .clock         (clock),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .instruction   (instruction),
        .rs1_value     (rs1_value),
        .rs2_value     (rs2_value),
`ifdef ALU_RV_BRANCH_EN
        .pc            (pc),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
`endif
        .rs1           (rs1),
        .rs2           (rs2),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .rd            (rd),
        .rd_result     (rd_result),
        .rd_write      (rd_write),
        .illegal       (illegal)
    );

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        wr;
        logic        ill;
    } vec_t;

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] s2,
                                          input logic [4:0] s1, input logic [2:0] f3,
                                          input logic [4:0] d);
        return {f7, s2, s1, f3, d, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] s1,
                                          input logic [2:0] f3, input logic [4:0] d);
        return {imm, s1, f3, d, 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] s2,
                                          input logic [4:0] s1, input logic [2:0] f3);
        return {imm[12], imm[10:5], s2, s1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    // Issue one op with out_ready=1 and capture the first result that follows it.
    task automatic exec(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                        output logic [4:0] o_rd, output logic [31:0] o_res,
                        output logic o_wr, output logic o_ill, output logic o_to);
        int   n;
        logic rdy;
        @(posedge clock); #1;
        instruction = ins; rs1_value = a; rs2_value = b; in_valid = 1'b1; out_ready = 1'b1;
        n = 0; rdy = 1'b0;
        while (!rdy && n < 20) begin
            @(negedge clock); rdy = in_ready;
            @(posedge clock); n++;
        end
        #1 in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clock); #1; n++;
        end
        o_rd = rd; o_res = rd_result; o_wr = rd_write; o_ill = illegal; o_to = !out_valid;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        instruction = 32'h0; rs1_value = 32'h0; rs2_value = 32'h0;
`ifdef ALU_RV_BRANCH_EN
        pc = 32'h0;
`endif
        #12;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (rd_result !== 32'h0) begin errors++; $display("FAIL reset_rd_result: got %h expected 0", rd_result); end
        checks++; if (rd_write !== 1'b0 || illegal !== 1'b0 || rd !== 5'd0) begin errors++; $display("FAIL reset_flags: got wr=%b ill=%b rd=%0d expected 0", rd_write, illegal, rd); end
        @(posedge clock); #1 reset = 1'b0;
        instruction = enc_r(7'h00, 5'd9, 5'd17, 3'd0, 5'd1);
        @(negedge clock);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (rs1 !== 5'd17 || rs2 !== 5'd9) begin errors++; $display("FAIL rs_fields: got rs1=%0d rs2=%0d expected 17 9", rs1, rs2); end
    endtask

    task automatic test_latency();
        @(posedge clock); #1;
        instruction = enc_i(12'hFFF, 5'd1, 3'd0, 5'd5);
        rs1_value = 32'h10; rs2_value = 32'hDEAD; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clock); #1 in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_early: got out_valid=%b expected 0", out_valid); end
        @(posedge clock); #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lat_valid: got %b expected 1", out_valid); end
        checks++; if (rd !== 5'd5 || rd_result !== 32'h0F || rd_write !== 1'b1 || illegal !== 1'b0) begin
            errors++; $display("FAIL lat_addi: got rd=%0d res=%h wr=%b ill=%b expected 5 0000000f 1 0", rd, rd_result, rd_write, illegal);
        end
        @(posedge clock); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_drain: got out_valid=%b expected 0", out_valid); end
    endtask

    task automatic test_alu_ops();
        vec_t        v[16];
        logic [4:0]  g_rd;
        logic [31:0] g_res;
        logic        g_wr, g_ill, g_to;
        v[0]  = '{enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd3),  32'h0,        32'h1,        32'hFFFFFFFF, 1'b1, 1'b0};
        v[1]  = '{enc_r(7'h20, 5'd2, 5'd1, 3'd5, 5'd4),  32'h80000000, 32'h4,        32'hF8000000, 1'b1, 1'b0};
        v[2]  = '{enc_r(7'h00, 5'd2, 5'd1, 3'd5, 5'd4),  32'h80000000, 32'h4,        32'h08000000, 1'b1, 1'b0};
        v[3]  = '{enc_r(7'h00, 5'd2, 5'd1, 3'd1, 5'd6),  32'h3,        32'h21,       32'h6,        1'b1, 1'b0};
        v[4]  = '{enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd7),  32'hFFFFFFFF, 32'h2,        32'h1,        1'b1, 1'b0};
        v[5]  = '{enc_r(7'h00, 5'd2, 5'd1, 3'd4, 5'd8),  32'hF0F0,     32'hFF00,     32'h0FF0,     1'b1, 1'b0};
        v[6]  = '{enc_r(7'h00, 5'd2, 5'd1, 3'd6, 5'd8),  32'hF0,       32'h0F,       32'hFF,       1'b1, 1'b0};
        v[7]  = '{enc_r(7'h00, 5'd2, 5'd1, 3'd7, 5'd8),  32'hF0F0,     32'hFF00,     32'hF000,     1'b1, 1'b0};
        v[8]  = '{enc_i(12'hFFF, 5'd1, 3'd3, 5'd9),      32'h5,        32'h0,        32'h1,        1'b1, 1'b0};
        v[9]  = '{enc_r(7'h00, 5'd2, 5'd1, 3'd2, 5'd10), 32'hFFFFFFFF, 32'h0,        32'h1,        1'b1, 1'b0};
        v[10] = '{enc_r(7'h00, 5'd2, 5'd1, 3'd3, 5'd10), 32'hFFFFFFFF, 32'h0,        32'h0,        1'b1, 1'b0};
        v[11] = '{enc_i(12'h400, 5'd1, 3'd0, 5'd11),     32'h1,        32'h7,        32'h401,      1'b1, 1'b0};
        v[12] = '{enc_i({7'h20, 5'd4}, 5'd1, 3'd5, 5'd12), 32'h80000000, 32'h0,      32'hF8000000, 1'b1, 1'b0};
        v[13] = '{enc_i({7'h00, 5'd4}, 5'd1, 3'd5, 5'd12), 32'h80000000, 32'h0,      32'h08000000, 1'b1, 1'b0};
        v[14] = '{enc_i(12'hFFE, 5'd1, 3'd2, 5'd13),     32'hFFFFFFFD, 32'h0,        32'h1,        1'b1, 1'b0};
        v[15] = '{enc_i(12'hFFF, 5'd1, 3'd7, 5'd14),     32'h12345678, 32'h0,        32'h12345678, 1'b1, 1'b0};
        for (int i = 0; i < 16; i++) begin
            exec(v[i].ins, v[i].a, v[i].b, g_rd, g_res, g_wr, g_ill, g_to);
            checks++;
            if (g_to || g_rd !== v[i].ins[11:7] || g_res !== v[i].res || g_wr !== v[i].wr || g_ill !== v[i].ill) begin
                errors++;
                $display("FAIL alu_op[%0d]: got to=%b rd=%0d res=%h wr=%b ill=%b expected rd=%0d res=%h wr=%b ill=%b",
                         i, g_to, g_rd, g_res, g_wr, g_ill, v[i].ins[11:7], v[i].res, v[i].wr, v[i].ill);
            end
        end
    endtask

    task automatic test_illegal();
        vec_t        v[7];
        logic [4:0]  g_rd;
        logic [31:0] g_res;
        logic        g_wr, g_ill, g_to;
        v[0] = '{{20'h12345, 5'd5, 7'b0110111},          32'h5, 32'h6, 32'h0, 1'b0, 1'b1};
        v[1] = '{enc_r(7'h01, 5'd2, 5'd1, 3'd0, 5'd5),   32'h5, 32'h6, 32'h0, 1'b0, 1'b1};
        v[2] = '{enc_r(7'h20, 5'd2, 5'd1, 3'd7, 5'd5),   32'h5, 32'h6, 32'h0, 1'b0, 1'b1};
        v[3] = '{enc_i({7'h01, 5'd3}, 5'd1, 3'd1, 5'd5), 32'h5, 32'h6, 32'h0, 1'b0, 1'b1};
        v[4] = '{enc_i({7'h40, 5'd1}, 5'd1, 3'd5, 5'd5), 32'h5, 32'h6, 32'h0, 1'b0, 1'b1};
        v[5] = '{enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd0),   32'h5, 32'h6, 32'hB, 1'b0, 1'b0};
        v[6] = '{enc_b(13'h0010, 5'd2, 5'd1, 3'd2),      32'h5, 32'h6, 32'h0, 1'b0, 1'b1};
        for (int i = 0; i < 7; i++) begin
            exec(v[i].ins, v[i].a, v[i].b, g_rd, g_res, g_wr, g_ill, g_to);
            checks++;
            if (g_to || g_res !== v[i].res || g_wr !== v[i].wr || g_ill !== v[i].ill) begin
                errors++;
                $display("FAIL illegal[%0d]: got to=%b res=%h wr=%b ill=%b expected res=%h wr=%b ill=%b",
                         i, g_to, g_res, g_wr, g_ill, v[i].res, v[i].wr, v[i].ill);
            end
        end
    endtask

    task automatic test_throughput();
        logic [31:0] ins[3];
        logic [31:0] er[3];
        ins[0] = enc_i(12'h001, 5'd1, 3'd0, 5'd1); er[0] = 32'h101;
        ins[1] = enc_i(12'h002, 5'd1, 3'd0, 5'd2); er[1] = 32'h102;
        ins[2] = enc_i(12'h003, 5'd1, 3'd0, 5'd3); er[2] = 32'h103;
        @(posedge clock); #1;
        out_ready = 1'b1; rs1_value = 32'h100; rs2_value = 32'h0;
        for (int c = 0; c < 5; c++) begin
            if (c < 3) begin instruction = ins[c]; in_valid = 1'b1; end
            else in_valid = 1'b0;
            @(negedge clock);
            if (c < 3) begin
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL tp_in_ready[%0d]: got %b expected 1", c, in_ready); end
            end
            if (c >= 2) begin
                checks++;
                if (out_valid !== 1'b1 || rd_result !== er[c-2]) begin
                    errors++; $display("FAIL tp_out[%0d]: got valid=%b res=%h expected 1 %h", c - 2, out_valid, rd_result, er[c-2]);
                end
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins[4];
        logic [31:0] av[4];
        logic [31:0] bv[4];
        logic [31:0] er[4];
        logic [31:0] got_res[$];
        logic [4:0]  got_rd[$];
        logic        saw_block;
        ins[0] = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd1); av[0] = 32'h1;   bv[0] = 32'h2;  er[0] = 32'h3;
        ins[1] = enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd2); av[1] = 32'hA;   bv[1] = 32'h3;  er[1] = 32'h7;
        ins[2] = enc_r(7'h00, 5'd2, 5'd1, 3'd4, 5'd3); av[2] = 32'hF0;  bv[2] = 32'hFF; er[2] = 32'h0F;
        ins[3] = enc_i(12'h00F, 5'd1, 3'd6, 5'd4);     av[3] = 32'h100; bv[3] = 32'h0;  er[3] = 32'h10F;
        saw_block = 1'b0;
        @(posedge clock); #1;
        out_ready = 1'b1;
        fork
            begin : producer
                int   n;
                logic rdy;
                for (int i = 0; i < 4; i++) begin
                    instruction = ins[i]; rs1_value = av[i]; rs2_value = bv[i]; in_valid = 1'b1;
                    n = 0; rdy = 1'b0;
                    while (!rdy && n < 30) begin
                        @(negedge clock); rdy = in_ready;
                        @(posedge clock); n++;
                    end
                    #1;
                end
                in_valid = 1'b0;
            end
            begin : ready_ctrl
                repeat (2) @(posedge clock);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clock);
                #1 out_ready = 1'b1;
            end
            begin : monitor
                logic        pv;
                logic [4:0]  prd;
                logic [31:0] pres;
                pv = 1'b0; prd = '0; pres = '0;
                for (int c = 0; c < 40 && got_res.size() < 4; c++) begin
                    @(negedge clock);
                    if (!in_ready) saw_block = 1'b1;
                    if (pv) begin
                        checks++;
                        if (out_valid !== 1'b1 || rd !== prd || rd_result !== pres) begin
                            errors++; $display("FAIL stall_hold: got valid=%b rd=%0d res=%h expected 1 %0d %h", out_valid, rd, rd_result, prd, pres);
                        end
                    end
                    pv = out_valid && !out_ready; prd = rd; pres = rd_result;
                    if (out_valid && out_ready) begin got_res.push_back(rd_result); got_rd.push_back(rd); end
                end
            end
        join
        checks++; if (saw_block !== 1'b1) begin errors++; $display("FAIL b2b_in_ready_drop: got saw_low=%b expected 1", saw_block); end
        checks++; if (got_res.size() != 4) begin errors++; $display("FAIL b2b_count: got %0d expected 4", got_res.size()); end
        for (int i = 0; i < 4 && i < got_res.size(); i++) begin
            checks++;
            if (got_res[i] !== er[i] || got_rd[i] !== ins[i][11:7]) begin
                errors++; $display("FAIL b2b_order[%0d]: got rd=%0d res=%h expected rd=%0d res=%h", i, got_rd[i], got_res[i], ins[i][11:7], er[i]);
            end
        end
        @(posedge clock); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_no_dup: got out_valid=%b expected 0", out_valid); end
    endtask

    task automatic test_reset_inflight();
        logic [4:0]  g_rd;
        logic [31:0] g_res;
        logic        g_wr, g_ill, g_to;
        @(posedge clock); #1;
        out_ready = 1'b0; rs1_value = 32'h1; rs2_value = 32'h0;
        instruction = enc_i(12'h001, 5'd1, 3'd0, 5'd1); in_valid = 1'b1;
        @(posedge clock); #1;
        instruction = enc_i(12'h002, 5'd1, 3'd0, 5'd2);
        @(posedge clock); #1;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_pre: got out_valid=%b expected 1", out_valid); end
        #2 reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || rd_result !== 32'h0) begin errors++; $display("FAIL rst_async: got valid=%b res=%h expected 0 0", out_valid, rd_result); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
        @(posedge clock); #1 reset = 1'b0; out_ready = 1'b1;
        @(posedge clock); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_stale: got out_valid=%b expected 0", out_valid); end
        exec(enc_i(12'h055, 5'd0, 3'd0, 5'd7), 32'h0, 32'h0, g_rd, g_res, g_wr, g_ill, g_to);
        checks++;
        if (g_to || g_rd !== 5'd7 || g_res !== 32'h55 || g_wr !== 1'b1) begin
            errors++; $display("FAIL rst_first_out: got to=%b rd=%0d res=%h wr=%b expected rd=7 res=00000055 wr=1", g_to, g_rd, g_res, g_wr);
        end
    endtask

`ifdef ALU_RV_BRANCH_EN
    task automatic test_branch();
        logic [4:0]  g_rd;
        logic [31:0] g_res;
        logic        g_wr, g_ill, g_to;
        pc = 32'h100;
        exec(enc_b(13'h1FF8, 5'd2, 5'd1, 3'd0), 32'h42, 32'h42, g_rd, g_res, g_wr, g_ill, g_to);
        checks++;
        if (g_to || branch_taken !== 1'b1 || branch_target !== 32'hF8 || g_wr !== 1'b0 || g_res !== 32'h0 || g_ill !== 1'b0) begin
            errors++; $display("FAIL br_beq: got to=%b taken=%b tgt=%h wr=%b res=%h ill=%b expected 1 000000f8 0 0 0", g_to, branch_taken, branch_target, g_wr, g_res, g_ill);
        end
        exec(enc_b(13'h1FF8, 5'd2, 5'd1, 3'd1), 32'h42, 32'h42, g_rd, g_res, g_wr, g_ill, g_to);
        checks++;
        if (g_to || branch_taken !== 1'b0 || branch_target !== 32'hF8) begin
            errors++; $display("FAIL br_bne: got to=%b taken=%b tgt=%h expected 0 000000f8", g_to, branch_taken, branch_target);
        end
        exec(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 32'h1, 32'h1, g_rd, g_res, g_wr, g_ill, g_to);
        checks++;
        if (g_to || branch_taken !== 1'b0 || branch_target !== 32'h0 || g_res !== 32'h2) begin
            errors++; $display("FAIL br_nonbranch: got to=%b taken=%b tgt=%h res=%h expected 0 0 2", g_to, branch_taken, branch_target, g_res);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_latency();
        test_alu_ops();
        test_illegal();
        test_throughput();
        test_back_to_back();
        test_reset_inflight();
`ifdef ALU_RV_BRANCH_EN
        test_branch();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
